// File: rtl/stack_ctrl.sv
// Stack pointer and control stage in front of the 2-read/1-write stack memory.
// Drives memory addresses and write strobe, returns TOS/NOS, holds sticky errors.
module stack_ctrl #(
    parameter int WIDTH = 6,
    parameter int SIZE  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [15:0]      push_data,
    output logic             op_ready,
    output logic [15:0]      tos,
    output logic [15:0]      nos,
    output logic [WIDTH:0]   depth,
    output logic             overflow,
    output logic             underflow,
    output logic [WIDTH-1:0] mem_dout_addr0,
    input  logic [15:0]      mem_dout0,
    output logic [WIDTH-1:0] mem_dout_addr1,
    input  logic [15:0]      mem_dout1,
    output logic             we,
    output logic [WIDTH-1:0] mem_din_addr,
    output logic [15:0]      mem_din
);
    typedef enum logic {IDLE, SWAP2} state_t;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_REPLACE = 3'd3;
    localparam logic [2:0] OP_DUP     = 3'd4;
    localparam logic [2:0] OP_SWAP    = 3'd5;
    localparam logic [2:0] OP_OVER    = 3'd6;
    localparam logic [2:0] OP_CLEAR   = 3'd7;

    localparam logic [WIDTH:0] FULL = (WIDTH+1)'(SIZE);
    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

    state_t           state, state_n;
    logic [WIDTH:0]   depth_n;
    logic [15:0]      tmp, tmp_n;
    logic             ovf_n, unf_n;
    logic [WIDTH-1:0] sp;
    logic             accept, has1, has2, full;

    // sp wraps to 0 when full, so sp-1 still addresses the top entry
    assign sp             = depth[WIDTH-1:0];
    assign mem_dout_addr0 = sp - WIDTH'(1);
    assign mem_dout_addr1 = sp - WIDTH'(2);

    assign has1     = depth != '0;
    assign has2     = depth > ONE;
    assign full     = depth == FULL;
    assign op_ready = state == IDLE;
    assign accept   = op_valid && op_ready;
    assign tos      = has1 ? mem_dout0 : 16'h0000;
    assign nos      = has2 ? mem_dout1 : 16'h0000;

    always_comb begin
        state_n      = state;
        depth_n      = depth;
        tmp_n        = tmp;
        ovf_n        = overflow;
        unf_n        = underflow;
        we           = 1'b0;
        mem_din_addr = sp;
        mem_din      = push_data;
        if (state == SWAP2) begin
            we           = 1'b1;
            mem_din_addr = mem_dout_addr1;
            mem_din      = tmp;
            state_n      = IDLE;
        end else if (accept) begin
            unique case (op)
                OP_PUSH: begin
                    if (full) ovf_n = 1'b1;
                    else begin
                        we      = 1'b1;
                        depth_n = depth + ONE;
                    end
                end
                OP_POP: begin
                    if (!has1) unf_n = 1'b1;
                    else depth_n = depth - ONE;
                end
                OP_REPLACE: begin
                    if (!has2) unf_n = 1'b1;
                    else begin
                        we           = 1'b1;
                        mem_din_addr = mem_dout_addr1;
                        depth_n      = depth - ONE;
                    end
                end
                OP_DUP: begin
                    if (!has1) unf_n = 1'b1;
                    else if (full) ovf_n = 1'b1;
                    else begin
                        we      = 1'b1;
                        mem_din = mem_dout0;
                        depth_n = depth + ONE;
                    end
                end
                OP_SWAP: begin
                    if (!has2) unf_n = 1'b1;
                    else begin
                        tmp_n        = mem_dout0;
                        we           = 1'b1;
                        mem_din_addr = mem_dout_addr0;
                        mem_din      = mem_dout1;
                        state_n      = SWAP2;
                    end
                end
                OP_OVER: begin
                    if (!has2) unf_n = 1'b1;
                    else if (full) ovf_n = 1'b1;
                    else begin
                        we      = 1'b1;
                        mem_din = mem_dout1;
                        depth_n = depth + ONE;
                    end
                end
                OP_CLEAR: begin
                    depth_n = '0;
                    ovf_n   = 1'b0;
                    unf_n   = 1'b0;
                end
                OP_NOP: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            depth     <= '0;
            tmp       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_n;
            depth     <= depth_n;
            tmp       <= tmp_n;
            overflow  <= ovf_n;
            underflow <= unf_n;
        end
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural stack model feeds a scoreboard of
// expected memory writes and post-op status, checked by a negedge monitor.
module tb_stack_ctrl;
    localparam int W = 6;
    localparam int N = 64;

    localparam int NOP = 0, PUSH = 1, POP = 2, REPL = 3;
    localparam int DUP = 4, SWAP = 5, OVER = 6, CLR = 7;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int depth;
        int tos;
        int nos;
        int ov;
        int un;
    } st_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [15:0]   push_data = 16'h0;
    logic          op_ready;
    logic [15:0]   tos, nos;
    logic [W:0]    depth;
    logic          overflow, underflow;
    logic [W-1:0]  mem_dout_addr0, mem_dout_addr1, mem_din_addr;
    logic [15:0]   mem_dout0, mem_dout1, mem_din;
    logic          we;

    logic [15:0]   mem [N];

    wr_t wq[$];
    st_t sq[$];
    int  stk[$];
    int  m_ov, m_un;
    int  n_pass = 0;
    int  n_tot = 0;
    int  pending = 0;

    stack_ctrl #(.WIDTH(W), .SIZE(N)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .push_data(push_data), .op_ready(op_ready), .tos(tos), .nos(nos),
        .depth(depth), .overflow(overflow), .underflow(underflow),
        .mem_dout_addr0(mem_dout_addr0), .mem_dout0(mem_dout0),
        .mem_dout_addr1(mem_dout_addr1), .mem_dout1(mem_dout1),
        .we(we), .mem_din_addr(mem_din_addr), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (we) mem[mem_din_addr] <= mem_din;
    assign mem_dout0 = mem[mem_dout_addr0];
    assign mem_dout1 = mem[mem_dout_addr1];

    task automatic check(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic st_t model_status();
        st_t s;
        int  n = stk.size();
        s.depth = n;
        s.tos   = (n >= 1) ? stk[n-1] : 0;
        s.nos   = (n >= 2) ? stk[n-2] : 0;
        s.ov    = m_ov;
        s.un    = m_un;
        return s;
    endfunction

    // Monitor: compares every write strobe and every completed op
    initial begin
        wr_t w;
        st_t s;
        forever begin
            @(negedge clk);
            if (reset) pending = 0;
            else begin
                if (we) begin
                    check("wr_expected", int'(wq.size() > 0), 1);
                    if (wq.size() > 0) begin
                        w = wq.pop_front();
                        check("wr_addr", int'(mem_din_addr), w.addr);
                        check("wr_data", int'(mem_din), w.data);
                    end
                end
                if (pending > 0 && op_ready) begin
                    pending--;
                    check("st_expected", int'(sq.size() > 0), 1);
                    if (sq.size() > 0) begin
                        s = sq.pop_front();
                        check("depth", int'(depth), s.depth);
                        check("tos", int'(tos), s.tos);
                        check("nos", int'(nos), s.nos);
                        check("overflow", int'(overflow), s.ov);
                        check("underflow", int'(underflow), s.un);
                    end
                end
                if (op_valid && op_ready) pending++;
            end
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 8 && !op_ready; k++) begin
            @(posedge clk);
            #1;
        end
        check("ready_timeout", int'(op_ready), 1);
    endtask

    task automatic do_op(input int o, input int d);
        int n = stk.size();
        int t;
        bit two = 1'b0;
        wait_ready();
        d = d & 16'hFFFF;
        case (o)
            PUSH: if (n >= N) m_ov = 1;
                  else begin
                      wq.push_back('{n % N, d});
                      stk.push_back(d);
                  end
            POP:  if (n < 1) m_un = 1;
                  else void'(stk.pop_back());
            REPL: if (n < 2) m_un = 1;
                  else begin
                      wq.push_back('{(n-2) % N, d});
                      void'(stk.pop_back());
                      void'(stk.pop_back());
                      stk.push_back(d);
                  end
            DUP:  if (n < 1) m_un = 1;
                  else if (n >= N) m_ov = 1;
                  else begin
                      wq.push_back('{n % N, stk[n-1]});
                      stk.push_back(stk[n-1]);
                  end
            SWAP: if (n < 2) m_un = 1;
                  else begin
                      wq.push_back('{(n-1) % N, stk[n-2]});
                      wq.push_back('{(n-2) % N, stk[n-1]});
                      t = stk[n-1];
                      stk[n-1] = stk[n-2];
                      stk[n-2] = t;
                      two = 1'b1;
                  end
            OVER: if (n < 2) m_un = 1;
                  else if (n >= N) m_ov = 1;
                  else begin
                      wq.push_back('{n % N, stk[n-2]});
                      stk.push_back(stk[n-2]);
                  end
            CLR: begin
                stk.delete();
                m_ov = 0;
                m_un = 0;
            end
            default: ;
        endcase
        sq.push_back(model_status());
        op_valid  = 1'b1;
        op        = 3'(o);
        push_data = 16'(d);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = 3'd0;
        if (two) begin
            check("swap_busy", int'(op_ready), 0);
            @(posedge clk);
            #1;
            check("swap_done", int'(op_ready), 1);
        end
    endtask

    task automatic do_reset();
        check("wq_drained", wq.size(), 0);
        reset    = 1'b1;
        op_valid = 1'b0;
        stk.delete();
        wq.delete();
        sq.delete();
        m_ov = 0;
        m_un = 0;
        #1;
        check("rst_depth", int'(depth), 0);
        check("rst_tos", int'(tos), 0);
        check("rst_nos", int'(nos), 0);
        check("rst_we", int'(we), 0);
        check("rst_ready", int'(op_ready), 1);
        check("rst_flags", int'({overflow, underflow}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        #2;
        do_reset();
        do_op(PUSH, 16'h1111);
        do_op(PUSH, 16'h2222);
        do_op(SWAP, 0);
        do_op(NOP, 0);

        do_reset();
        do_op(PUSH, 16'h1111);
        do_op(PUSH, 16'h2222);
        do_op(REPL, 16'h3333);
        do_op(OVER, 0);

        do_reset();
        for (int i = 0; i < N; i++) do_op(PUSH, i);
        do_op(PUSH, 16'h0BAD);
        do_op(DUP, 0);
        do_op(POP, 0);
        do_op(CLR, 0);

        do_reset();
        do_op(POP, 0);
        do_op(DUP, 0);

        // Reset arriving while the second SWAP write is pending
        do_reset();
        do_op(PUSH, 16'hAAAA);
        do_op(PUSH, 16'hBBBB);
        wait_ready();
        wq.push_back('{1, 16'hAAAA});
        op_valid = 1'b1;
        op       = 3'(SWAP);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        check("abort_busy", int'(op_ready), 0);
        reset = 1'b1;
        #1;
        check("abort_ready", int'(op_ready), 1);
        check("abort_depth", int'(depth), 0);
        check("abort_we", int'(we), 0);
        stk.delete();
        sq.delete();
        m_ov = 0;
        m_un = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle_we", int'(we), 0);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 11);
            if (r >= 8) r = PUSH;
            if (r == CLR && $urandom_range(0, 7) != 0) r = PUSH;
            do_op(r, $urandom_range(0, 65535));
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_wq", wq.size(), 0);
        check("final_sq", sq.size(), 0);
        check("final_pending", pending, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
